// File: rtl/bus_sync_pkg.sv
// Shared types and defaults for the bus_sync feeder slice.
// Imported by the interface, FIFO and feeder top.
package bus_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_RDY
    } feed_state_t;

    localparam int DWIDTH_DEF  = 4;
    localparam int DEPTH_DEF   = 8;
    localparam int ACK_TMO_DEF = 16;

endpackage

// File: rtl/bus_sync_feeder_if.sv
// Upstream write stream plus the metered link into bus_sync.
// slave = feeder side, master = producer/bus_sync side.
interface bus_sync_feeder_if
    import bus_sync_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);

    logic [DWIDTH-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic [DWIDTH-1:0] o_sync_data;
    logic              o_sync_valid;
    logic              i_sync_ready;

    modport master (
        output i_data,
        output i_valid,
        output i_sync_ready,
        input  o_ready,
        input  o_sync_data,
        input  o_sync_valid
    );

    modport slave (
        input  i_data,
        input  i_valid,
        input  i_sync_ready,
        output o_ready,
        output o_sync_data,
        output o_sync_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no read-side bypass.
// Writes are refused while full, even if a read happens that cycle.
module sync_fifo
    import bus_sync_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_sync_feeder.sv
// Buffers a valid/ready stream and meters single-cycle pulses into bus_sync,
// waiting for its ready to drop and recover between words.
module bus_sync_feeder
    import bus_sync_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ACK_TMO = ACK_TMO_DEF
) (
    input  logic                   i_clk,
    input  logic                   rst_n,
    bus_sync_feeder_if.slave       bus,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_tmo_err,
    input  logic                   i_clr_err
);

    localparam int TW = $clog2(ACK_TMO);

    feed_state_t       state;
    logic [TW-1:0]     timer;
    logic [DWIDTH-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign pop         = (state == IDLE) && !fifo_empty && bus.i_sync_ready;
    assign bus.o_ready = !fifo_full;

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (rst_n),
        .wr_en   (bus.i_valid),
        .wr_data (bus.i_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .count   (o_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A timeout set later in this block overrides a same-cycle clear
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            timer            <= '0;
            o_tmo_err        <= 1'b0;
            bus.o_sync_data  <= '0;
            bus.o_sync_valid <= 1'b0;
        end else begin
            if (i_clr_err) o_tmo_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.o_sync_data  <= fifo_data;
                        bus.o_sync_valid <= 1'b1;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    bus.o_sync_valid <= 1'b0;
                    timer            <= '0;
                    state            <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!bus.i_sync_ready) begin
                        state <= WAIT_RDY;
                    end else if (timer == TW'(ACK_TMO - 1)) begin
                        o_tmo_err <= 1'b1;
                        state     <= WAIT_RDY;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (bus.i_sync_ready) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sync_feeder.sv
// Self-checking bench: scoreboard + bus_sync responder model, directed
// vector table, corner-case sequences and a randomized stream.
module tb_bus_sync_feeder;
    import bus_sync_pkg::*;

    localparam int DW      = 4;
    localparam int DEPTH   = 8;
    localparam int ACK_TMO = 16;
    localparam int M_NORM   = 0;
    localparam int M_NODROP = 1;
    localparam int M_LOW    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] count;
    logic       tmo_err;

    bus_sync_feeder_if #(.DWIDTH(DW)) bus();

    bus_sync_feeder #(
        .DWIDTH  (DW),
        .DEPTH   (DEPTH),
        .ACK_TMO (ACK_TMO)
    ) dut (
        .i_clk     (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .o_count   (count),
        .o_tmo_err (tmo_err),
        .i_clr_err (clr_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [3:0] mq[$];
    int         mc = 0;
    int         mode = M_NORM;
    int         resp_cnt = 0;
    int         rx_cnt = 0;
    logic [3:0] held = '0;
    logic       prev_valid = 1'b0;
    logic       last_pop = 1'b0;
    logic       chk_tmo = 1'b1;

    typedef struct {
        logic [3:0] din;
        logic [3:0] dout;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // One clock: model the FIFO as a queue, score pops, run the responder
    task automatic step();
        logic       wr;
        logic [3:0] wd;
        logic       rdy_b;
        logic       pop;
        wr    = bus.i_valid && rst_n && (mc != DEPTH);
        wd    = bus.i_data;
        rdy_b = bus.i_sync_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            last_pop = 1'b0;
            return;
        end
        if (wr) mq.push_back(wd);
        pop      = bus.o_sync_valid;
        last_pop = pop;
        if (pop) begin
            rx_cnt++;
            chk("pop_needs_ready", rdy_b, 1);
            chk("pop_needs_word", mc > 0, 1);
            chk("single_pulse", prev_valid, 0);
            if (mq.size() > 0) begin
                chk("order", bus.o_sync_data, mq[0]);
                void'(mq.pop_front());
            end
            held = bus.o_sync_data;
        end
        mc = mc + (wr ? 1 : 0) - (pop ? 1 : 0);
        if (mc < 0) mc = 0;
        prev_valid = pop;
        chk("count", count, mc);
        chk("o_ready", bus.o_ready, mc != DEPTH);
        if (chk_tmo) chk("tmo_idle", tmo_err, 0);
        case (mode)
            M_NORM: begin
                if (pop) begin
                    resp_cnt = 1;
                end else if (resp_cnt > 0) begin
                    chk("data_hold", bus.o_sync_data, held);
                    resp_cnt++;
                end
                if (resp_cnt >= 9) resp_cnt = 0;
                bus.i_sync_ready = (resp_cnt < 3);
            end
            M_NODROP: begin
                resp_cnt = 0;
                bus.i_sync_ready = 1'b1;
            end
            default: begin
                resp_cnt = 0;
                bus.i_sync_ready = 1'b0;
            end
        endcase
    endtask

    task automatic wr_word(input logic [3:0] d);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int idle;
        idle = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (mc == 0 && resp_cnt == 0) idle++;
            else idle = 0;
            if (idle >= 3) break;
        end
        chk("drain_done", idle >= 3, 1);
        chk("drain_empty", mq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[6];
        int         lat;
        int         rx0;
        logic [3:0] got;

        vt[0] = '{4'hA, 4'hA, 1};
        vt[1] = '{4'h0, 4'h0, 1};
        vt[2] = '{4'hF, 4'hF, 1};
        vt[3] = '{4'h5, 4'h5, 1};
        vt[4] = '{4'h3, 4'h3, 1};
        vt[5] = '{4'hC, 4'hC, 1};

        bus.i_valid      = 1'b0;
        bus.i_data       = '0;
        bus.i_sync_ready = 1'b1;

        // reset state
        #12;
        chk("rst_valid", bus.o_sync_valid, 0);
        chk("rst_data", bus.o_sync_data, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_tmo", tmo_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single words from empty: pulse one edge after the write
        for (int i = 0; i < 6; i++) begin
            wr_word(vt[i].din);
            chk("tbl_no_early", last_pop, 0);
            lat = 0;
            got = '0;
            for (int k = 1; k <= 5; k++) begin
                step();
                if (last_pop) begin
                    lat = k;
                    got = bus.o_sync_data;
                    break;
                end
            end
            chk("tbl_latency", lat, vt[i].lat);
            chk("tbl_data", got, vt[i].dout);
            drain();
        end

        // burst of 10 with valid held high
        rx0 = rx_cnt;
        bus.i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.i_data = 4'(i);
            step();
        end
        bus.i_valid = 1'b0;
        chk("burst_full_cnt", count, 8);
        chk("burst_full_rdy", bus.o_ready, 0);
        drain();
        chk("burst_rx", rx_cnt - rx0, 9);

        // write and pop together at count 3
        mode = M_LOW;
        bus.i_sync_ready = 1'b0;
        wr_word(4'h1);
        wr_word(4'h2);
        wr_word(4'h3);
        step();
        mode = M_NORM;
        bus.i_sync_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 4'h7;
        step();
        bus.i_valid = 1'b0;
        chk("simul_pop", last_pop, 1);
        chk("simul_cnt3", count, 3);
        drain();

        // write refused at full even with a pop
        mode = M_LOW;
        bus.i_sync_ready = 1'b0;
        bus.i_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.i_data = 4'(8 + i);
            step();
        end
        bus.i_valid = 1'b0;
        chk("full_cnt", count, 8);
        mode = M_NORM;
        bus.i_sync_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 4'hE;
        step();
        bus.i_valid = 1'b0;
        chk("full_pop", last_pop, 1);
        chk("full_refused", count, 7);
        drain();

        // timeout with clear held high: set wins
        mode = M_NODROP;
        chk_tmo = 1'b0;
        clr_err = 1'b1;
        wr_word(4'h6);
        step();
        chk("tmo_pop", last_pop, 1);
        for (int k = 1; k <= ACK_TMO + 1; k++) begin
            step();
            chk("tmo_timing", tmo_err, k == ACK_TMO + 1);
        end
        clr_err = 1'b0;
        mode = M_NORM;
        rx0 = rx_cnt;
        wr_word(4'h9);
        drain();
        chk("tmo_next_sent", rx_cnt - rx0, 1);
        chk("tmo_sticky", tmo_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("tmo_clear", tmo_err, 0);
        chk_tmo = 1'b1;

        // ready held low for 50 cycles with 3 queued
        mode = M_LOW;
        bus.i_sync_ready = 1'b0;
        wr_word(4'hB);
        wr_word(4'h4);
        wr_word(4'hD);
        rx0 = rx_cnt;
        repeat (50) step();
        chk("low_no_valid", rx_cnt - rx0, 0);
        chk("low_cnt", count, 3);
        mode = M_NORM;
        bus.i_sync_ready = 1'b1;
        drain();
        chk("low_rx", rx_cnt - rx0, 3);

        // reset while in WAIT_ACK with one word still buffered
        bus.i_valid = 1'b1;
        bus.i_data  = 4'h1;
        step();
        bus.i_data  = 4'h2;
        step();
        bus.i_valid = 1'b0;
        chk("mid_pop", last_pop, 1);
        step();
        chk("mid_cnt", count, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.o_sync_valid, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_ready", bus.o_ready, 1);
        mq.delete();
        mc = 0;
        resp_cnt = 0;
        prev_valid = 1'b0;
        bus.i_sync_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        rx0 = rx_cnt;
        repeat (6) step();
        chk("mid_no_resend", rx_cnt - rx0, 0);

        // randomized stream against the scoreboard
        for (int i = 0; i < 600; i++) begin
            if (i < 300) bus.i_valid = ($urandom % 3) != 0;
            else bus.i_valid = ($urandom % 5) == 0;
            bus.i_data = 4'($urandom);
            step();
        end
        bus.i_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
